// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding, default
// field widths and the layout of one {note, duration} song ROM entry.
package song_pkg;

    localparam int DEFAULT_NOTE_W = 6;
    localparam int DEFAULT_DUR_W  = 6;
    localparam int DEFAULT_SONG_W = 2;
    localparam int DEFAULT_IDX_W  = 5;

    // ROM entry layout: note in the upper field, duration in the lower field
    localparam int ENTRY_DUR_LSB  = 0;
    localparam int ENTRY_DUR_MSB  = DEFAULT_DUR_W - 1;
    localparam int ENTRY_NOTE_LSB = DEFAULT_DUR_W;
    localparam int ENTRY_NOTE_MSB = DEFAULT_DUR_W + DEFAULT_NOTE_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        LOAD,
        WAIT_DONE,
        END
    } state_t;

endpackage

// File: rtl/song_sequencer.sv
// Steps note_player through {note, duration} entries of an external synchronous song ROM.
// Define SONG_SEQUENCER_LOOP_EN to restart a finished song at index 0 instead of idling.
module song_sequencer
    import song_pkg::*;
#(
    parameter int NOTE_W = DEFAULT_NOTE_W,
    parameter int DUR_W  = DEFAULT_DUR_W,
    parameter int SONG_W = DEFAULT_SONG_W,
    parameter int IDX_W  = DEFAULT_IDX_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    output logic                    song_done,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note_to_load,
    output logic [DUR_W-1:0]        duration_to_load,
    output logic                    load_new_note,
    input  logic                    done_with_note,
    output logic                    play_enable
);

    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    state_t              state;
    logic [SONG_W-1:0]   song_q;
    logic [IDX_W-1:0]    idx_q;
    logic                marker_q;
    logic                song_changed;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_dur      = rom_data[ENTRY_DUR_LSB +: DUR_W];
    assign rom_note     = rom_data[ENTRY_DUR_LSB + DUR_W +: NOTE_W];
    assign song_changed = (song != song_q);
    assign rom_addr     = {song_q, idx_q};

    // Gating is combinational on play so note_player freezes in the same cycle play drops
    assign play_enable  = play && (state inside {FETCH, WAIT_DATA, LOAD, WAIT_DONE});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            song_q           <= '0;
            idx_q            <= '0;
            marker_q         <= 1'b0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
        end else begin
            load_new_note <= 1'b0;
            song_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (play) begin
                        song_q <= song;
                        idx_q  <= '0;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    state <= song_changed ? IDLE : WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (song_changed) begin
                        state <= IDLE;
                    end else begin
                        // A zero duration is the end-of-song marker: keep the last note on the outputs
                        marker_q <= (rom_dur == '0);
                        if (rom_dur != '0) begin
                            note_to_load     <= rom_note;
                            duration_to_load <= rom_dur;
                            load_new_note    <= 1'b1;
                        end
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (song_changed) begin
                        state <= IDLE;
                    end else if (marker_q) begin
                        song_done <= 1'b1;
                        state     <= END;
                    end else begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (song_changed) begin
                        state <= IDLE;
                    end else if (done_with_note) begin
                        if (idx_q == IDX_LAST) begin
                            song_done <= 1'b1;
                            state     <= END;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                END: begin
`ifdef SONG_SEQUENCER_LOOP_EN
                    idx_q <= '0;
                    state <= FETCH;
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
